// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter driving the select lines of a 4:1 mux with a per-grant hold limit.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       addr0,
  output logic       addr1,
  output logic       sel_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] own, own_n, ptr, ptr_n, base, win;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [3:0] grant_n;
  logic rel, found;
  assign rel   = (state == GRANT) && (!req[own] || cnt == HOLD_W'(MAX_HOLD - 1));
  assign base  = rel ? own + 2'd1 : ptr;
  assign found = |req;
  // Descending scan so the nearest requester after base is the last one written.
  always_comb begin
    win = base;
    for (int k = 3; k >= 0; k--)
      if (req[base + 2'(k)]) win = base + 2'(k);
  end
  always_comb begin
    state_n = state;
    own_n   = own;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = grant;
    if (state == GRANT && !rel) cnt_n = cnt + HOLD_W'(1);
    else begin
      if (rel) ptr_n = base;
      if (found) begin
        state_n = GRANT;
        own_n   = win;
        cnt_n   = '0;
        grant_n = 4'b0001 << win;
      end else if (rel) begin
        state_n = IDLE;
        grant_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      own   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      own   <= own_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      grant <= grant_n;
    end
  // Address follows the owner register, so it holds the last owner while idle.
  assign addr0     = own[0];
  assign addr1     = own[1];
  assign sel_valid = |grant;
endmodule
